ws2812_rx: RTL and testbench
============================

# ws2812_rx

WS2812 single-wire receiver: samples a WS2812-format bitstream and decodes it back into 24-bit pixel words with their per-frame index. It also detects the reset/latch gap that ends a frame and flags malformed pulses. It is the receive end of the strip transmitter. It sits on a loopback pin so the bench and on-board self-test can check the pixel order and colour data actually driven onto `ws2812_dout`.

## Interface
Parameters:
- `BITS_PER_PIXEL`, 24: bits per pixel word; shifted in MSB first.
- `PX_COUNT_WIDTH`, 6: width of the pixel index and count outputs.
- `T_MIN_HIGH`, 15: minimum legal high time, in clk cycles.
- `T_THRESH`, 60: a high time at or above this decodes as 1; below it decodes as 0.
- `T_MAX_HIGH`, 120: a high time reaching this value is an error.
- `T_MAX_LOW`, 1000: a low time inside a pixel, or between pixels, at or above this and below `T_RESET` is an error.
- `T_RESET`, 5000: a low time of this length (50 µs at 100 MHz) ends the frame.

Ports:
- `clk`, in, 1: 100 MHz system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `din`, in, 1: raw WS2812 data line, asynchronous to `clk`.
- `pixel`, out, `BITS_PER_PIXEL`: last decoded pixel word; holds its value between updates.
- `pixel_valid`, out, 1: one-cycle strobe when `pixel` and `px_index` update.
- `px_index`, out, `PX_COUNT_WIDTH`: zero-based index of `pixel` within the current frame.
- `frame_done`, out, 1: one-cycle strobe when a reset gap ends a frame.
- `frame_px_count`, out, `PX_COUNT_WIDTH`: number of complete pixels in the frame just ended; valid with `frame_done` and held afterwards.
- `err`, out, 1: one-cycle strobe on a protocol violation.

## Operation
- `din` passes through a 2-flop synchronizer to give `din_s`. The FSM uses only `din_s` and its registered copy for edge detection.
- A single cycle counter `cnt` has width `$clog2(T_RESET+1)`. It saturates at `T_RESET` and clears on every `din_s` edge.

FSM states:
- **SYNC**
  - Entered on reset and after any error.
  - Waits until `din_s` has been low for `T_RESET` consecutive cycles, then moves to READY.
  - Any high on `din_s` restarts the count.
  - No strobes are issued in SYNC.
- **READY**
  - Waits for a rising edge, then moves to HIGH.
  - On entry, `bit_cnt` = 0 and the pixel counter = 0.
- **HIGH**
  - Counts the high time.
  - If `cnt` reaches `T_MAX_HIGH`: err, go to SYNC.
  - On the falling edge:
    - If `cnt` < `T_MIN_HIGH`: err, go to SYNC.
    - Otherwise shift in the bit (`cnt` >= `T_THRESH` → 1) and increment `bit_cnt`.
    - When `bit_cnt` reaches `BITS_PER_PIXEL`: load `pixel`, drive `px_index` = pixel counter, pulse `pixel_valid`, increment the pixel counter (wraps modulo 2^`PX_COUNT_WIDTH`), clear `bit_cnt`.
    - Go to LOW.
- **LOW**
  - Counts the low time.
  - Rising edge with `cnt` < `T_MAX_LOW`: go to HIGH.
  - Rising edge with `T_MAX_LOW` <= `cnt` < `T_RESET`: err, go to SYNC.
  - `cnt` reaching `T_RESET`:
    - If `bit_cnt` ≠ 0: err, discard the partial pixel, go to READY. No `frame_done` is issued.
    - Otherwise: pulse `frame_done`, set `frame_px_count` = pixel counter (0 wraps for exactly 2^`PX_COUNT_WIDTH` pixels), go to READY.

Error handling:
- An error discards any partial pixel.
- An error never asserts `pixel_valid` or `frame_done` on the same cycle.

Reset:
- All outputs are 0 and the FSM is in SYNC.
- A reset mid-frame drops all partial state. After release the block resynchronizes on the next gap, so the rest of an in-progress frame is ignored without an error.

## Timing
- Synchronizer latency is 2 cycles; output strobes are registered.
- `pixel_valid` rises 1 cycle after the cycle in which `din_s` shows the final falling edge, which is 3 cycles after the `din` pin edge.
- `frame_done` rises 1 cycle after `cnt` reaches `T_RESET` in LOW.
- `err` rises 1 cycle after the violation is detected.
- `pixel_valid`, `frame_done` and `err` are mutually exclusive and each is exactly 1 cycle wide.
- No backpressure: the consumer must accept every strobe.
- Minimum supported bit period is 2×`T_MIN_HIGH` cycles.

## Configuration
- `WS2812_RX_STATS_EN`
  - Defined: adds output `err_count` [15:0]. It increments on each `err` strobe, saturates at 16'hFFFF, and clears only on `rst`.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Hold `din` low for 5000 cycles after reset, then send pixel 24'hA5C30F with T0H=40/T1H=80 and 125-cycle bit periods, then a 5000-cycle low gap:
  - one `pixel_valid` with `pixel`=24'hA5C30F and `px_index`=0;
  - then `frame_done` with `frame_px_count`=1.
- Send 52 pixels whose values equal their index, then a gap:
  - 52 strobes with `px_index` 0..51;
  - `frame_px_count`=52;
  - `err` never asserted.
- Drive a 10-cycle high pulse mid-pixel:
  - `err` pulses once;
  - no `pixel_valid`;
  - the following full frame, after a 5000-cycle gap, decodes correctly.
- Send a 150-cycle high pulse:
  - `err` is asserted when `cnt`=120;
  - FSM returns to SYNC.
- Send 12 bits, then a 5000-cycle low:
  - `err` pulses once;
  - no `frame_done`.
- Assert `rst` mid-pixel, release it, then continue the stream without a gap:
  - no strobes until a 5000-cycle low is seen;
  - the next frame decodes normally.
- With `WS2812_RX_STATS_EN` defined, inject 3 errors: `err_count`=3.

Source files
------------

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: decodes pixels, frame gaps and protocol errors.
// Optional `WS2812_RX_STATS_EN adds a saturating 16-bit err_count output.
module ws2812_rx #(
  parameter int BITS_PER_PIXEL = 24,
  parameter int PX_COUNT_WIDTH = 6,
  parameter int T_MIN_HIGH     = 15,
  parameter int T_THRESH       = 60,
  parameter int T_MAX_HIGH     = 120,
  parameter int T_MAX_LOW      = 1000,
  parameter int T_RESET        = 5000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din,
  output logic [BITS_PER_PIXEL-1:0] pixel,
  output logic                      pixel_valid,
  output logic [PX_COUNT_WIDTH-1:0] px_index,
  output logic                      frame_done,
  output logic [PX_COUNT_WIDTH-1:0] frame_px_count,
  output logic                      err
`ifdef WS2812_RX_STATS_EN
  ,
  output logic [15:0]               err_count
`endif
);

  localparam int CW = $clog2(T_RESET + 1);
  localparam int BW = $clog2(BITS_PER_PIXEL + 1);

  localparam logic [CW-1:0] C_MIN_HIGH = CW'(T_MIN_HIGH);
  localparam logic [CW-1:0] C_THRESH   = CW'(T_THRESH);
  localparam logic [CW-1:0] C_MAX_HIGH = CW'(T_MAX_HIGH);
  localparam logic [CW-1:0] C_MAX_LOW  = CW'(T_MAX_LOW);
  localparam logic [CW-1:0] C_RESET    = CW'(T_RESET);
  localparam logic [BW-1:0] C_LAST_BIT = BW'(BITS_PER_PIXEL - 1);

  localparam logic [1:0] S_SYNC  = 2'd0;
  localparam logic [1:0] S_READY = 2'd1;
  localparam logic [1:0] S_HIGH  = 2'd2;
  localparam logic [1:0] S_LOW   = 2'd3;

  logic                      din_meta;
  logic                      din_s;
  logic                      din_d;
  logic [CW-1:0]             cnt;
  logic [1:0]                state;
  logic [BW-1:0]             bit_cnt;
  logic [PX_COUNT_WIDTH-1:0] px_cnt;
  logic [BITS_PER_PIXEL-2:0] shift;
  logic                      rise;
  logic                      fall;
  logic                      bit_val;

  assign rise    = din_s & ~din_d;
  assign fall    = ~din_s & din_d;
  assign bit_val = (cnt >= C_THRESH);

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_meta <= 1'b0;
      din_s    <= 1'b0;
      din_d    <= 1'b0;
    end else begin
      din_meta <= din;
      din_s    <= din_meta;
      din_d    <= din_s;
    end
  end

  // Level-time counter: restarts on any edge, saturates at the reset-gap length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise || fall) begin
      cnt <= '0;
    end else if (cnt != C_RESET) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= cnt;
    end
  end

  // Protocol FSM with registered pixel, frame and error strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_SYNC;
      bit_cnt        <= '0;
      px_cnt         <= '0;
      shift          <= '0;
      pixel          <= '0;
      pixel_valid    <= 1'b0;
      px_index       <= '0;
      frame_done     <= 1'b0;
      frame_px_count <= '0;
      err            <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      case (state)
        S_SYNC: begin
          // din_d low excludes the falling-edge cycle, where cnt still holds a saturated high time.
          if (!din_s && !din_d && cnt == C_RESET) begin
            state   <= S_READY;
            bit_cnt <= '0;
            px_cnt  <= '0;
          end
        end
        S_READY: begin
          if (rise) begin
            state <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (cnt >= C_MAX_HIGH) begin
            err   <= 1'b1;
            state <= S_SYNC;
          end else if (fall) begin
            if (cnt < C_MIN_HIGH) begin
              err   <= 1'b1;
              state <= S_SYNC;
            end else begin
              state <= S_LOW;
              shift <= {shift[BITS_PER_PIXEL-3:0], bit_val};
              if (bit_cnt == C_LAST_BIT) begin
                pixel       <= {shift, bit_val};
                px_index    <= px_cnt;
                pixel_valid <= 1'b1;
                px_cnt      <= px_cnt + 1'b1;
                bit_cnt     <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        S_LOW: begin
          if (rise) begin
            if (cnt < C_MAX_LOW) begin
              state <= S_HIGH;
            end else begin
              err   <= 1'b1;
              state <= S_SYNC;
            end
          end else if (cnt == C_RESET) begin
            state   <= S_READY;
            bit_cnt <= '0;
            px_cnt  <= '0;
            if (bit_cnt != '0) begin
              err <= 1'b1;
            end else begin
              frame_done     <= 1'b1;
              frame_px_count <= px_cnt;
            end
          end
        end
        default: begin
          state <= S_SYNC;
        end
      endcase
    end
  end

`ifdef WS2812_RX_STATS_EN
  // Saturating error counter, cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 16'h0000;
    end else if (err && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'h0001;
    end else begin
      err_count <= err_count;
    end
  end
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed self-checking bench for ws2812_rx (build with +define+WS2812_RX_STATS_EN for err_count).
module tb_ws2812_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic [23:0] pixel;
  logic        pixel_valid;
  logic [5:0]  px_index;
  logic        frame_done;
  logic [5:0]  frame_px_count;
  logic        err;
`ifdef WS2812_RX_STATS_EN
  logic [15:0] err_count;
`endif

  int checks = 0;
  int errors = 0;

  int pv_n = 0;
  int fd_n = 0;
  int err_n = 0;
  int overlap_n = 0;
  int wide_n = 0;
  logic pv_prev = 1'b0;
  logic fd_prev = 1'b0;
  logic err_prev = 1'b0;
  logic [23:0] px_q[$];
  logic [5:0]  idx_q[$];

  ws2812_rx dut (
    .clk            (clk),
    .rst            (rst),
    .din            (din),
    .pixel          (pixel),
    .pixel_valid    (pixel_valid),
    .px_index       (px_index),
    .frame_done     (frame_done),
    .frame_px_count (frame_px_count),
    .err            (err)
`ifdef WS2812_RX_STATS_EN
    ,
    .err_count      (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Strobe logger, sampled on the inactive edge.
  always @(negedge clk) begin
    if (pixel_valid) begin
      pv_n++;
      px_q.push_back(pixel);
      idx_q.push_back(px_index);
    end
    if (frame_done) fd_n++;
    if (err) err_n++;
    if ((int'(pixel_valid) + int'(frame_done) + int'(err)) > 1) overlap_n++;
    if ((pixel_valid && pv_prev) || (frame_done && fd_prev) || (err && err_prev)) wide_n++;
    pv_prev  = pixel_valid;
    fd_prev  = frame_done;
    err_prev = err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int high, input int period);
    din = 1'b1;
    repeat (high) @(negedge clk);
    din = 1'b0;
    repeat (period - high) @(negedge clk);
  endtask

  // 125-cycle bit period, T0H=40, T1H=80.
  task automatic send_px_slow(input logic [23:0] v);
    for (int i = 23; i >= 0; i--) pulse(v[i] ? 80 : 40, 125);
  endtask

  // Short bits: 20 high / 10 low for 0, 70 high / 10 low for 1; sends v[n-1:0] MSB first.
  task automatic send_bits(input logic [23:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (v[i]) pulse(70, 80);
      else      pulse(20, 30);
    end
  endtask

  int b_pv, b_fd, b_err;

  task automatic mark();
    b_pv  = pv_n;
    b_fd  = fd_n;
    b_err = err_n;
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pixel", 32'(pixel), 32'h0);
    check("rst_pv", 32'(pixel_valid), 32'h0);
    check("rst_idx", 32'(px_index), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    check("rst_fpc", 32'(frame_px_count), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    idle(5020);

    // Single slow pixel then frame gap.
    mark();
    send_px_slow(24'hA5C30F);
    idle(5020);
    check("t1_pv_count", 32'(pv_n - b_pv), 32'd1);
    check("t1_pixel", 32'(px_q[b_pv]), 32'h00A5C30F);
    check("t1_index", 32'(idx_q[b_pv]), 32'd0);
    check("t1_fd_count", 32'(fd_n - b_fd), 32'd1);
    check("t1_fpc", 32'(frame_px_count), 32'd1);
    check("t1_err", 32'(err_n - b_err), 32'd0);

    // 52 pixels whose value equals their index.
    mark();
    for (int p = 0; p < 52; p++) send_bits(24'(p), 24);
    idle(5020);
    check("t2_pv_count", 32'(pv_n - b_pv), 32'd52);
    if (pv_n - b_pv == 52) begin
      for (int p = 0; p < 52; p++) begin
        check("t2_pixel", 32'(px_q[b_pv + p]), 32'(p));
        check("t2_index", 32'(idx_q[b_pv + p]), 32'(p));
      end
    end
    check("t2_fd_count", 32'(fd_n - b_fd), 32'd1);
    check("t2_fpc", 32'(frame_px_count), 32'd52);
    check("t2_err", 32'(err_n - b_err), 32'd0);

    // Runt 10-cycle high pulse mid-pixel, resync, clean pixel.
    mark();
    send_bits(24'h0000B7, 8);
    pulse(10, 30);
    idle(5020);
    check("t3_err_count", 32'(err_n - b_err), 32'd1);
    check("t3_no_pv", 32'(pv_n - b_pv), 32'd0);
    check("t3_no_fd", 32'(fd_n - b_fd), 32'd0);
    mark();
    send_bits(24'h123456, 24);
    check("t3_pv_count", 32'(pv_n - b_pv), 32'd1);
    check("t3_pixel", 32'(px_q[pv_n - 1]), 32'h00123456);
    check("t3_index", 32'(idx_q[pv_n - 1]), 32'd0);

    // 150-cycle high pulse straight from LOW: err fires inside the pulse after 120 cycles.
    mark();
    din = 1'b1;
    repeat (100) @(negedge clk);
    check("t4_no_err_early", 32'(err_n - b_err), 32'd0);
    repeat (50) @(negedge clk);
    check("t4_err_in_pulse", 32'(err_n - b_err), 32'd1);
    idle(20);
    send_bits(24'h000000, 24);
    check("t4_sync_no_pv", 32'(pv_n - b_pv), 32'd0);
    check("t4_sync_no_err", 32'(err_n - b_err), 32'd1);
    idle(5020);

    // 12 bits then a gap: error, no frame_done.
    mark();
    send_bits(24'h000ABC, 12);
    idle(5020);
    check("t5_err_count", 32'(err_n - b_err), 32'd1);
    check("t5_no_fd", 32'(fd_n - b_fd), 32'd0);
    check("t5_no_pv", 32'(pv_n - b_pv), 32'd0);
`ifdef WS2812_RX_STATS_EN
    check("stats_err_count", 32'(err_count), 32'd3);
`endif

    // Reset mid-pixel, stream continues without gap.
    send_bits(24'h0003A5, 10);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_rst_pixel", 32'(pixel), 32'h0);
    check("t6_rst_fpc", 32'(frame_px_count), 32'h0);
`ifdef WS2812_RX_STATS_EN
    check("t6_rst_err_count", 32'(err_count), 32'd0);
`endif
    rst = 1'b0;
    mark();
    send_bits(24'h0012C4, 14);
    send_bits(24'h00FF00, 24);
    check("t6_no_pv", 32'(pv_n - b_pv), 32'd0);
    check("t6_no_err", 32'(err_n - b_err), 32'd0);
    check("t6_no_fd", 32'(fd_n - b_fd), 32'd0);
    idle(5020);
    send_bits(24'hC0FFEE, 24);
    check("t6_pv_count", 32'(pv_n - b_pv), 32'd1);
    check("t6_pixel", 32'(px_q[pv_n - 1]), 32'h00C0FFEE);
    check("t6_index", 32'(idx_q[pv_n - 1]), 32'd0);
    check("t6_err", 32'(err_n - b_err), 32'd0);

    check("strobe_overlap", 32'(overlap_n), 32'd0);
    check("strobe_width", 32'(wide_n), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
